// File: rtl/m_mem_arb.sv
// m_mem_arb: arbitrates an instruction-fetch port and a data port onto one
// single-port synchronous RAM (1-cycle read latency).
//
// Ports:
//   w_clk, w_rst            clock, asynchronous active-high reset
//   w_if_req/addr           fetch read request (byte address)
//   w_if_gnt/vld/rdata      fetch grant (combinational), read return
//   w_dm_req/we/addr/wdata  data read/write request (byte address)
//   w_dm_gnt/vld/rdata      data grant (combinational), read return
//   w_mem_en/we/addr/wdata  RAM request, w_mem_rdata RAM read data
//   w_stall                 some requester is pending but not granted
//
// Build option:
//   MEM_ARB_RR_EN  defined   -> conflicts resolved round-robin
//                  undefined -> data wins, fetch forced after STARVE_MAX
//                               consecutive denied cycles
module m_mem_arb #(
    parameter int unsigned AW         = 10,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic          w_clk,
    input  logic          w_rst,
    input  logic          w_if_req,
    input  logic [31:0]   w_if_addr,
    output logic          w_if_gnt,
    output logic          w_if_vld,
    output logic [31:0]   w_if_rdata,
    input  logic          w_dm_req,
    input  logic          w_dm_we,
    input  logic [31:0]   w_dm_addr,
    input  logic [31:0]   w_dm_wdata,
    output logic          w_dm_gnt,
    output logic          w_dm_vld,
    output logic [31:0]   w_dm_rdata,
    output logic          w_mem_en,
    output logic          w_mem_we,
    output logic [AW-1:0] w_mem_addr,
    output logic [31:0]   w_mem_wdata,
    input  logic [31:0]   w_mem_rdata,
    output logic          w_stall
);

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RET_IF = 2'd1,
        RET_DM = 2'd2
    } ret_state_e;

    ret_state_e    state_q, state_d;
    logic          if_act, dm_act, conflict, if_wins;
    logic [DW-1:0] if_hold_q, dm_hold_q;

    // Requests are masked while reset is held so nothing is granted.
    assign if_act   = w_if_req & ~w_rst;
    assign dm_act   = w_dm_req & ~w_rst;
    assign conflict = if_act & dm_act;

`ifdef MEM_ARB_RR_EN
    // Priority pointer: 1 = fetch wins the next conflict.
    logic rr_if_prio_q;

    assign if_wins = rr_if_prio_q;

    // The winner of a conflict loses priority for the next one.
    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            rr_if_prio_q <= 1'b1;
        end else if (conflict) begin
            rr_if_prio_q <= ~rr_if_prio_q;
        end
    end
`else
    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);
    localparam logic [CW-1:0] CNT_SAT    = '1;

    logic [CW-1:0] starve_q;

    assign if_wins = (starve_q >= STARVE_LIM);

    // Saturating count of consecutive denied fetch cycles; holds while idle.
    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            starve_q <= '0;
        end else if (w_if_gnt) begin
            starve_q <= '0;
        end else if (w_if_req && (starve_q != CNT_SAT)) begin
            starve_q <= starve_q + CW'(1);
        end
    end
`endif

    // Grant selection: lone requester always wins, conflicts go to if_wins.
    always_comb begin
        w_if_gnt = 1'b0;
        w_dm_gnt = 1'b0;
        if (conflict) begin
            w_if_gnt = if_wins;
            w_dm_gnt = ~if_wins;
        end else begin
            w_if_gnt = if_act;
            w_dm_gnt = dm_act;
        end
    end

    // RAM request path.
    assign w_mem_en    = w_if_gnt | w_dm_gnt;
    assign w_mem_we    = w_dm_gnt & w_dm_we;
    assign w_mem_addr  = w_if_gnt ? w_if_addr[AW+1:2] : w_dm_addr[AW+1:2];
    assign w_mem_wdata = w_dm_wdata;
    assign w_stall     = (if_act & ~w_if_gnt) | (dm_act & ~w_dm_gnt);

    // Read-return FSM state register.
    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Read-return FSM next state: remembers who owns next cycle's RAM data.
    always_comb begin
        state_d = IDLE;
        if (w_if_gnt) begin
            state_d = RET_IF;
        end else if (w_dm_gnt && !w_dm_we) begin
            state_d = RET_DM;
        end
    end

    assign w_if_vld = (state_q == RET_IF);
    assign w_dm_vld = (state_q == RET_DM);

    // Last delivered word per requester, shown while no return is in flight.
    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            if_hold_q <= '0;
            dm_hold_q <= '0;
        end else begin
            if (w_if_vld) begin
                if_hold_q <= w_mem_rdata;
            end
            if (w_dm_vld) begin
                dm_hold_q <= w_mem_rdata;
            end
        end
    end

    assign w_if_rdata = w_if_vld ? w_mem_rdata : if_hold_q;
    assign w_dm_rdata = w_dm_vld ? w_mem_rdata : dm_hold_q;

    // Byte-lane and above-depth address bits carry no meaning here.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{w_if_addr[DW-1:AW+2], w_if_addr[1:0],
                                w_dm_addr[DW-1:AW+2], w_dm_addr[1:0]};

endmodule

// File: tb/tb_m_mem_arb.sv
// tb_m_mem_arb: directed bench for m_mem_arb with a behavioural single-port
// RAM and a queue of expected read returns per cycle.
module tb_m_mem_arb;

    localparam int unsigned AW    = 10;
    localparam int unsigned DEPTH = 1 << AW;

    typedef enum logic [1:0] {R_NONE, R_IF, R_DM} ret_kind_e;
    typedef struct packed {
        ret_kind_e   kind;
        logic [31:0] data;
    } ret_t;

    logic          w_clk;
    logic          w_rst;
    logic          w_if_req;
    logic [31:0]   w_if_addr;
    logic          w_if_gnt;
    logic          w_if_vld;
    logic [31:0]   w_if_rdata;
    logic          w_dm_req;
    logic          w_dm_we;
    logic [31:0]   w_dm_addr;
    logic [31:0]   w_dm_wdata;
    logic          w_dm_gnt;
    logic          w_dm_vld;
    logic [31:0]   w_dm_rdata;
    logic          w_mem_en;
    logic          w_mem_we;
    logic [AW-1:0] w_mem_addr;
    logic [31:0]   w_mem_wdata;
    logic [31:0]   w_mem_rdata;
    logic          w_stall;

    logic [31:0] ram     [DEPTH];
    logic [31:0] ref_mem [DEPTH];
    ret_t        sb[$];
    int          n_checks = 0;
    int          n_err    = 0;
    logic [31:0] last_if  = 32'h0;
    logic [31:0] last_dm  = 32'h0;

    m_mem_arb #(.AW(AW), .STARVE_MAX(4)) dut (
        .w_clk       (w_clk),
        .w_rst       (w_rst),
        .w_if_req    (w_if_req),
        .w_if_addr   (w_if_addr),
        .w_if_gnt    (w_if_gnt),
        .w_if_vld    (w_if_vld),
        .w_if_rdata  (w_if_rdata),
        .w_dm_req    (w_dm_req),
        .w_dm_we     (w_dm_we),
        .w_dm_addr   (w_dm_addr),
        .w_dm_wdata  (w_dm_wdata),
        .w_dm_gnt    (w_dm_gnt),
        .w_dm_vld    (w_dm_vld),
        .w_dm_rdata  (w_dm_rdata),
        .w_mem_en    (w_mem_en),
        .w_mem_we    (w_mem_we),
        .w_mem_addr  (w_mem_addr),
        .w_mem_wdata (w_mem_wdata),
        .w_mem_rdata (w_mem_rdata),
        .w_stall     (w_stall)
    );

    initial w_clk = 1'b0;
    always #5 w_clk = ~w_clk;

    // Single-port synchronous RAM, 1-cycle read latency.
    always @(posedge w_clk) begin
        if (w_mem_en) begin
            if (w_mem_we) ram[w_mem_addr] <= w_mem_wdata;
            else          w_mem_rdata     <= ram[w_mem_addr];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare this cycle's return against the entry queued one cycle earlier.
    task automatic check_ret(input string tag);
        ret_t e;
        e = ret_t'{R_NONE, 32'h0};
        if (sb.size() != 0) e = sb.pop_front();
        check({tag, ":if_vld"}, 32'(w_if_vld), 32'(e.kind == R_IF));
        check({tag, ":dm_vld"}, 32'(w_dm_vld), 32'(e.kind == R_DM));
        if (e.kind == R_IF) last_if = e.data;
        if (e.kind == R_DM) last_dm = e.data;
        check({tag, ":if_rdata"}, w_if_rdata, last_if);
        check({tag, ":dm_rdata"}, w_dm_rdata, last_dm);
    endtask

    // One clock cycle: drive, check grants/RAM request, queue expected return.
    task automatic cycle(input string tag,
                         input logic ir, input logic [31:0] ia,
                         input logic dr, input logic dwe,
                         input logic [31:0] da, input logic [31:0] dwd,
                         input logic eig, input logic edg);
        logic [AW-1:0] wi;
        w_if_req   = ir;
        w_if_addr  = ia;
        w_dm_req   = dr;
        w_dm_we    = dwe;
        w_dm_addr  = da;
        w_dm_wdata = dwd;
        #3;
        check_ret(tag);
        check({tag, ":if_gnt"}, 32'(w_if_gnt), 32'(eig));
        check({tag, ":dm_gnt"}, 32'(w_dm_gnt), 32'(edg));
        check({tag, ":stall"}, 32'(w_stall), 32'((ir & ~eig) | (dr & ~edg)));
        check({tag, ":mem_en"}, 32'(w_mem_en), 32'(eig | edg));
        check({tag, ":mem_we"}, 32'(w_mem_we), 32'(edg & dwe));
        check({tag, ":mem_wdata"}, w_mem_wdata, dwd);
        if (eig) begin
            wi = ia[AW+1:2];
            check({tag, ":mem_addr"}, 32'(w_mem_addr), 32'(wi));
            sb.push_back(ret_t'{R_IF, ref_mem[wi]});
        end else if (edg) begin
            wi = da[AW+1:2];
            check({tag, ":mem_addr"}, 32'(w_mem_addr), 32'(wi));
            if (dwe) begin
                ref_mem[wi] = dwd;
                sb.push_back(ret_t'{R_NONE, 32'h0});
            end else begin
                sb.push_back(ret_t'{R_DM, ref_mem[wi]});
            end
        end else begin
            sb.push_back(ret_t'{R_NONE, 32'h0});
        end
        @(posedge w_clk);
        #1;
    endtask

    // Hold reset for one cycle with both requests up, then release.
    task automatic reset_phase(input string tag);
        w_rst    = 1'b1;
        w_if_req = 1'b1;
        w_dm_req = 1'b1;
        w_dm_we  = 1'b0;
        #3;
        check({tag, ":if_gnt"}, 32'(w_if_gnt), 32'd0);
        check({tag, ":dm_gnt"}, 32'(w_dm_gnt), 32'd0);
        check({tag, ":if_vld"}, 32'(w_if_vld), 32'd0);
        check({tag, ":dm_vld"}, 32'(w_dm_vld), 32'd0);
        check({tag, ":mem_en"}, 32'(w_mem_en), 32'd0);
        check({tag, ":mem_we"}, 32'(w_mem_we), 32'd0);
        check({tag, ":stall"}, 32'(w_stall), 32'd0);
        check({tag, ":if_rdata"}, w_if_rdata, 32'h0);
        check({tag, ":dm_rdata"}, w_dm_rdata, 32'h0);
        @(posedge w_clk);
        #1;
        w_rst    = 1'b0;
        w_if_req = 1'b0;
        w_dm_req = 1'b0;
        sb.delete();
        sb.push_back(ret_t'{R_NONE, 32'h0});
        last_if = 32'h0;
        last_dm = 32'h0;
    endtask

    initial begin
        logic eig;
        w_rst      = 1'b1;
        w_if_req   = 1'b0;
        w_if_addr  = 32'h0;
        w_dm_req   = 1'b0;
        w_dm_we    = 1'b0;
        w_dm_addr  = 32'h0;
        w_dm_wdata = 32'h0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            ram[i]     = 32'(i) * 32'h9E37_79B1 + 32'h0000_1234;
            ref_mem[i] = 32'(i) * 32'h9E37_79B1 + 32'h0000_1234;
        end
        ram[2]     = 32'h0070_0093;
        ref_mem[2] = 32'h0070_0093;

        @(posedge w_clk);
        #1;
        reset_phase("rst");

        // Lone fetch, lone store, read-backs, byte bits ignored, idle.
        cycle("fetch8",  1'b1, 32'h8,  1'b0, 1'b0, 32'h0,  32'h0, 1'b1, 1'b0);
        cycle("store8",  1'b0, 32'h0,  1'b1, 1'b1, 32'h8,  32'h7, 1'b0, 1'b1);
        cycle("dread8",  1'b0, 32'h0,  1'b1, 1'b0, 32'h8,  32'h0, 1'b0, 1'b1);
        cycle("fetch8b", 1'b1, 32'hB,  1'b0, 1'b0, 32'h0,  32'h0, 1'b1, 1'b0);
        cycle("fetch13", 1'b1, 32'h13, 1'b0, 1'b0, 32'h0,  32'h0, 1'b1, 1'b0);
        cycle("dread1e", 1'b0, 32'h0,  1'b1, 1'b0, 32'h1E, 32'h0, 1'b0, 1'b1);
        cycle("idle",    1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  32'h0, 1'b0, 1'b0);

        // Fetch granted, reset rises the next cycle: no return.
        cycle("prerst",  1'b1, 32'hC,  1'b0, 1'b0, 32'h0,  32'h0, 1'b1, 1'b0);
        reset_phase("midrst");

        // First cycle after reset release can be granted.
        cycle("postrst", 1'b1, 32'h8,  1'b0, 1'b0, 32'h0,  32'h0, 1'b1, 1'b0);

        // Continuous conflict from a known arbitration state.
        for (int i = 0; i < 10; i++) begin
`ifdef MEM_ARB_RR_EN
            eig = ((i % 2) == 0);
`else
            eig = ((i % 5) == 4);
`endif
            cycle($sformatf("conf%0d", i), 1'b1, 32'h10, 1'b1, 1'b0, 32'h14, 32'h0, eig, ~eig);
        end

`ifndef MEM_ARB_RR_EN
        // Starvation count holds while fetch is not requesting.
        cycle("hold0", 1'b1, 32'h20, 1'b1, 1'b0, 32'h24, 32'h0, 1'b0, 1'b1);
        cycle("hold1", 1'b1, 32'h20, 1'b1, 1'b0, 32'h24, 32'h0, 1'b0, 1'b1);
        cycle("hold2", 1'b0, 32'h20, 1'b1, 1'b0, 32'h28, 32'h0, 1'b0, 1'b1);
        cycle("hold3", 1'b0, 32'h20, 1'b1, 1'b1, 32'h2C, 32'hA5A5_0001, 1'b0, 1'b1);
        cycle("hold4", 1'b1, 32'h20, 1'b1, 1'b0, 32'h2C, 32'h0, 1'b0, 1'b1);
        cycle("hold5", 1'b1, 32'h20, 1'b1, 1'b0, 32'h24, 32'h0, 1'b0, 1'b1);
        cycle("hold6", 1'b1, 32'h20, 1'b1, 1'b0, 32'h24, 32'h0, 1'b1, 1'b0);
`endif

        // Single requesters after conflicts, then drain.
        cycle("dalone", 1'b0, 32'h0,  1'b1, 1'b0, 32'h8, 32'h0, 1'b0, 1'b1);
        cycle("ialone", 1'b1, 32'h30, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        cycle("drain",  1'b0, 32'h0,  1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
